mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised load/store unit sitting between execute and write-back in the multi-cycle/pipelined core. Takes one load or store per handshake, generates aligned memory address, byte enables and lane-shifted store data, waits on a variable-latency data memory, then sign/zero-extends load data and presents it for write-back. Supports RV32 and RV64 widths, detects misaligned accesses and illegal widths, and keeps exactly one transaction outstanding.

## Interface
- XLEN, 32: data width, 32 or 64 only.
- ADDR_W, 32: byte address width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  unit can accept an access.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_rd  in  5  load destination register.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  address aligned down to XLEN/8.
- mem_wdata  out  XLEN  store data shifted into byte lanes.
- mem_be  out  XLEN/8  byte enables.
- mem_rsp_valid  in  1  load data valid, one cycle.
- mem_rdata  in  XLEN  full aligned word/doubleword.
- wb_valid  out  1  load result valid, one-cycle pulse.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  extended load result.
- exc_valid  out  1  exception pulse, one cycle.
- exc_cause  out  2  0 = load misaligned, 1 = store misaligned, 2 = illegal width.
- exc_addr  out  ADDR_W  faulting byte address.

## Operation
- funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; signed unless funct3[2]=1.
- Illegal: 111 always; 011 and 110 when XLEN=32; any store with funct3[2]=1.
- Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0. Illegal takes priority over misaligned.
- Lane offset = addr mod XLEN/8. mem_be = size mask (1/3/F/FF) shifted left by offset. mem_wdata = req_wdata low bytes shifted left by 8×offset; unused lanes zero. mem_addr = addr with low log2(XLEN/8) bits cleared.
- Load: extract bytes at offset from mem_rdata, sign- or zero-extend to XLEN.
- States: IDLE, REQ, WAIT, RESP, EXC.
  - IDLE: req_ready=1. On req_valid: illegal/misaligned → EXC; else latch fields → REQ.
  - REQ: mem_req_valid=1; address, data, be, we held stable until mem_req_ready. On accept: store → IDLE; load → WAIT.
  - WAIT: on mem_rsp_valid capture extended data → RESP.
  - RESP: wb_valid=1 with wb_rd, wb_data → IDLE.
  - EXC: exc_valid=1 with cause and addr → IDLE.
- mem_rsp_valid outside WAIT is ignored. Loads to rd=0 still access memory and pulse wb_valid with wb_rd=0.
- Stores produce no wb_valid.

## Timing
- Reset: state IDLE; req_ready=1; mem_req_valid, mem_we, wb_valid, exc_valid=0; mem_addr, mem_wdata, mem_be, wb_rd, wb_data, exc_cause, exc_addr all zero.
- req_ready is 0 in every state except IDLE; no new request is accepted in the cycle a transaction completes.
- Store latency: accept at T, mem_req_valid from T+1, done the cycle mem_req_ready is seen, req_ready high the next cycle.
- Load latency: accept T, request T+1 (if ready), response earliest T+2, wb_valid the cycle after the response; minimum 4 cycles accept-to-accept.
- Exception: exc_valid at T+1, req_ready at T+2; mem_req_valid never asserted.
- mem_req_valid is never dropped before mem_req_ready.
- Reset mid-transaction: returns to IDLE next edge, the pending wb/exc is discarded, and a late mem_rsp_valid is ignored.

## Test plan
- XLEN=32 LB addr 0x103, mem_rdata 0x80FF1234 → mem_addr 0x100, mem_be 4'b1000, wb_data 0xFFFFFF80 one cycle after response.
- XLEN=32 LHU addr 0x102, same rdata → wb_data 0x000080FF; LH → 0xFFFF80FF.
- XLEN=32 SB addr 0x101, wdata 0x000000AB, mem_req_ready low 3 cycles → mem_req_valid and mem_wdata 0x0000AB00, mem_be 4'b0010 held stable 4 cycles; no wb_valid.
- LW addr 0x102 → exc_valid, cause 0, addr 0x102 at T+1; no mem_req_valid. SW funct3=110 → cause 2.
- XLEN=64 LD addr 0x8, rdata 0x8000000000000001 → mem_be 8'hFF, wb_data unchanged; LWU addr 0xC → 0x0000000080000000.
- rst asserted in WAIT, then mem_rsp_valid → no wb_valid, all outputs at reset values, req_ready=1.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundle of execute-side request, data-memory and write-back/exception
// signals for mem_access_unit. The unit connects through the slave
// modport; the surrounding core (or a bench) uses master.
interface mem_access_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  // execute-stage request
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  // data memory
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;
  // write-back and exception
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              exc_valid;
  logic [1:0]        exc_cause;
  logic [ADDR_W-1:0] exc_addr;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output wb_valid, wb_rd, wb_data,
    output exc_valid, exc_cause, exc_addr
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  wb_valid, wb_rd, wb_data,
    input  exc_valid, exc_cause, exc_addr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one access in flight, lane alignment of store data and
// byte enables, sign/zero extension of load data, misaligned and
// illegal-width exceptions. XLEN must be 32 or 64.
module mem_access_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic             clk,
  input logic             rst,
  mem_access_unit_if.slave bus
);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, EXC} state_t;

  state_t state, state_n;

  // request decode
  logic [2:0]        f3;
  logic              illegal;
  logic              misaligned;
  logic              fault;
  logic [OFF_W-1:0]  off;
  logic [7:0]        mask8;
  logic [NB-1:0]     size_mask;
  logic [NB-1:0]     be_n;
  logic [XLEN-1:0]   wmask;
  logic [XLEN-1:0]   wdata_n;
  logic [ADDR_W-1:0] addr_al;
  logic              accept;

  // held transaction state
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [NB-1:0]     mem_be_q;
  logic [2:0]        ld_f3_q;
  logic [OFF_W-1:0]  ld_off_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [1:0]        exc_cause_q;
  logic [ADDR_W-1:0] exc_addr_q;

  // load extraction
  logic [XLEN-1:0]   rsh;
  logic [XLEN-1:0]   ext;

  // Decode width, detect faults, and build lane-aligned be/wdata/address.
  always_comb begin
    f3         = bus.req_funct3;
    off        = bus.req_addr[OFF_W-1:0];
    illegal    = (f3 == 3'b111) || (bus.req_we && f3[2]) ||
                 ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
    mask8      = 8'h01;
    misaligned = 1'b0;
    case (f3[1:0])
      2'd0: begin mask8 = 8'h01; misaligned = 1'b0;                           end
      2'd1: begin mask8 = 8'h03; misaligned = bus.req_addr[0];                end
      2'd2: begin mask8 = 8'h0F; misaligned = (bus.req_addr[1:0] != 2'b00);  end
      default: begin mask8 = 8'hFF; misaligned = (bus.req_addr[2:0] != 3'b000); end
    endcase
    fault     = illegal || misaligned;
    size_mask = mask8[NB-1:0];
    be_n      = size_mask << off;
    wmask     = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wmask[8*i +: 8] = {8{size_mask[i]}};
    end
    wdata_n = (bus.req_wdata & wmask) << {off, 3'b000};
    addr_al = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  // Shift the returned word down to the access offset and extend it.
  always_comb begin
    rsh = bus.mem_rdata >> {ld_off_q, 3'b000};
    case (ld_f3_q)
      3'b000:  ext = XLEN'($signed(rsh[7:0]));
      3'b100:  ext = XLEN'(rsh[7:0]);
      3'b001:  ext = XLEN'($signed(rsh[15:0]));
      3'b101:  ext = XLEN'(rsh[15:0]);
      3'b010:  ext = XLEN'($signed(rsh[31:0]));
      3'b110:  ext = XLEN'(rsh[31:0]);
      default: ext = rsh;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake/pulse outputs.
  always_comb begin
    state_n           = state;
    accept            = 1'b0;
    bus.req_ready     = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.exc_valid     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_n = fault ? EXC : REQ;
        end
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_n = mem_we_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (bus.mem_rsp_valid) state_n = RESP;
      end
      RESP: begin
        bus.wb_valid = 1'b1;
        state_n      = IDLE;
      end
      EXC: begin
        bus.exc_valid = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture request fields on accept and load data on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      ld_f3_q     <= '0;
      ld_off_q    <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      if (accept) begin
        if (fault) begin
          exc_cause_q <= illegal ? 2'd2 : (bus.req_we ? 2'd1 : 2'd0);
          exc_addr_q  <= bus.req_addr;
        end else begin
          mem_we_q    <= bus.req_we;
          mem_addr_q  <= addr_al;
          mem_be_q    <= be_n;
          mem_wdata_q <= bus.req_we ? wdata_n : '0;
          ld_f3_q     <= f3;
          ld_off_q    <= off;
          if (!bus.req_we) wb_rd_q <= bus.req_rd;
        end
      end
      if ((state == WAIT) && bus.mem_rsp_valid) wb_data_q <= ext;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.exc_cause = exc_cause_q;
  assign bus.exc_addr  = exc_addr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: an RV32 and an RV64 instance share stimulus
// variables; sel64 routes the request and memory inputs to one of them.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit          sel64 = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [4:0]  rd = '0;
  logic        mem_req_ready = 1'b0, rsp_valid = 1'b0;
  logic [63:0] rdata = '0;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) if32 ();
  mem_access_unit_if #(.XLEN(64), .ADDR_W(32)) if64 ();

  mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  mem_access_unit #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  assign if32.req_valid     = req_valid & ~sel64;
  assign if32.req_we        = req_we;
  assign if32.req_funct3    = f3;
  assign if32.req_addr      = addr;
  assign if32.req_wdata     = wdata[31:0];
  assign if32.req_rd        = rd;
  assign if32.mem_req_ready = mem_req_ready & ~sel64;
  assign if32.mem_rsp_valid = rsp_valid & ~sel64;
  assign if32.mem_rdata     = rdata[31:0];
  assign if64.req_valid     = req_valid & sel64;
  assign if64.req_we        = req_we;
  assign if64.req_funct3    = f3;
  assign if64.req_addr      = addr;
  assign if64.req_wdata     = wdata;
  assign if64.req_rd        = rd;
  assign if64.mem_req_ready = mem_req_ready & sel64;
  assign if64.mem_rsp_valid = rsp_valid & sel64;
  assign if64.mem_rdata     = rdata;

  logic        o_req_ready, o_mem_req_valid, o_mem_we, o_wb_valid, o_exc_valid;
  logic [31:0] o_mem_addr, o_exc_addr;
  logic [63:0] o_mem_wdata, o_wb_data;
  logic [7:0]  o_mem_be;
  logic [4:0]  o_wb_rd;
  logic [1:0]  o_exc_cause;

  always_comb begin
    if (sel64) begin
      o_req_ready = if64.req_ready;  o_mem_req_valid = if64.mem_req_valid;
      o_mem_we = if64.mem_we;        o_mem_addr = if64.mem_addr;
      o_mem_wdata = if64.mem_wdata;  o_mem_be = if64.mem_be;
      o_wb_valid = if64.wb_valid;    o_wb_rd = if64.wb_rd;
      o_wb_data = if64.wb_data;      o_exc_valid = if64.exc_valid;
      o_exc_cause = if64.exc_cause;  o_exc_addr = if64.exc_addr;
    end else begin
      o_req_ready = if32.req_ready;  o_mem_req_valid = if32.mem_req_valid;
      o_mem_we = if32.mem_we;        o_mem_addr = if32.mem_addr;
      o_mem_wdata = {32'h0, if32.mem_wdata}; o_mem_be = {4'h0, if32.mem_be};
      o_wb_valid = if32.wb_valid;    o_wb_rd = if32.wb_rd;
      o_wb_data = {32'h0, if32.wb_data}; o_exc_valid = if32.exc_valid;
      o_exc_cause = if32.exc_cause;  o_exc_addr = if32.exc_addr;
    end
  end

  // Last values seen by run(), for directed constant checks.
  logic [31:0] last_maddr, last_eaddr;
  logic [7:0]  last_be;
  logic [63:0] last_wdata, last_wb;
  logic [1:0]  last_cause;
  bit          last_exc, saw_mem;

  // Reference: an access of 2^f3[1:0] bytes in an xl-bit word.
  function automatic void model(input int xl, input bit we, input logic [2:0] f,
                                input logic [31:0] a, input logic [63:0] wd,
                                input logic [63:0] word, output bit exc,
                                output logic [1:0] cause, output logic [31:0] maddr,
                                output logic [7:0] be, output logic [63:0] wsh,
                                output logic [63:0] ld);
    int nb, size, off;
    bit illegal, mis;
    logic [63:0] lanes;
    nb      = xl / 8;
    size    = 1 << f[1:0];
    off     = int'(a % nb);
    illegal = (f == 3'd7) || (we && f[2]) || (xl == 32 && (f == 3'd3 || f == 3'd6));
    mis     = (a % size) != 0;
    exc     = illegal || mis;
    cause   = illegal ? 2'd2 : (we ? 2'd1 : 2'd0);
    maddr   = a - off;
    be      = 8'(((1 << size) - 1) << off);
    lanes   = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    wsh     = (wd & lanes) << (8 * off);
    ld      = (word >> (8 * off)) & lanes;
    if (!f[2] && ld[8 * size - 1]) ld = ld | ~lanes;
    if (xl == 32) ld = ld & 64'hFFFF_FFFF;
  endfunction

  // One complete transaction from the task's own entry (posedge+1) to IDLE.
  task automatic run(input bit s64, input bit we, input logic [2:0] f,
                     input logic [31:0] a, input logic [63:0] wd, input logic [4:0] r,
                     input logic [63:0] word, input int stall, input int lat);
    bit e_exc;
    logic [1:0] e_cause;
    logic [31:0] e_maddr;
    logic [7:0] e_be;
    logic [63:0] e_wsh, e_ld;
    model(s64 ? 64 : 32, we, f, a, wd, word, e_exc, e_cause, e_maddr, e_be, e_wsh, e_ld);
    last_exc = 1'b0;
    saw_mem  = 1'b0;
    sel64 = s64; req_we = we; f3 = f; addr = a; wdata = wd; rd = r; req_valid = 1'b1;
    @(negedge clk);
    total++;
    if (o_req_ready !== 1'b1) begin
      bad++; $display("FAIL accept_ready: got %b want 1", o_req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); f3 = 3'($urandom); addr = $urandom;
    wdata = {$urandom, $urandom}; rd = 5'($urandom);
    if (e_exc) begin
      @(negedge clk);
      total++;
      last_exc = 1'b1; last_cause = o_exc_cause; last_eaddr = o_exc_addr;
      if (o_exc_valid !== 1'b1 || o_exc_cause !== e_cause || o_exc_addr !== a ||
          o_mem_req_valid !== 1'b0 || o_req_ready !== 1'b0 || o_wb_valid !== 1'b0) begin
        bad++;
        $display("FAIL exc_pulse: got v=%b cause=%0d addr=%h mreq=%b rdy=%b want v=1 cause=%0d addr=%h mreq=0 rdy=0",
                 o_exc_valid, o_exc_cause, o_exc_addr, o_mem_req_valid, o_req_ready, e_cause, a);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (o_exc_valid !== 1'b0 || o_req_ready !== 1'b1 || o_mem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL exc_done: got v=%b rdy=%b mreq=%b want v=0 rdy=1 mreq=0",
                 o_exc_valid, o_req_ready, o_mem_req_valid);
      end
      @(posedge clk); #1;
      return;
    end
    // Request phase; stray responses while stalled must be ignored.
    for (int i = 0; i <= stall; i++) begin
      mem_req_ready = (i == stall);
      rsp_valid     = (i < stall);
      rdata         = {$urandom, $urandom};
      @(negedge clk);
      total++;
      saw_mem = 1'b1; last_maddr = o_mem_addr; last_be = o_mem_be; last_wdata = o_mem_wdata;
      if (o_mem_req_valid !== 1'b1 || o_mem_we !== we || o_mem_addr !== e_maddr ||
          o_mem_be !== e_be || (we && o_mem_wdata !== e_wsh) || o_wb_valid !== 1'b0 ||
          o_req_ready !== 1'b0 || o_exc_valid !== 1'b0) begin
        bad++;
        $display("FAIL mem_req: got v=%b we=%b addr=%h be=%h wd=%h wb=%b rdy=%b want v=1 we=%b addr=%h be=%h wd=%h",
                 o_mem_req_valid, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, o_wb_valid,
                 o_req_ready, we, e_maddr, e_be, e_wsh);
      end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    rsp_valid     = 1'b0;
    if (!we) begin
      for (int j = 0; j < lat; j++) begin
        @(negedge clk);
        total++;
        if (o_mem_req_valid !== 1'b0 || o_wb_valid !== 1'b0 || o_req_ready !== 1'b0) begin
          bad++;
          $display("FAIL wait_idle: got mreq=%b wb=%b rdy=%b want 0 0 0",
                   o_mem_req_valid, o_wb_valid, o_req_ready);
        end
        @(posedge clk); #1;
      end
      rsp_valid = 1'b1;
      rdata     = word;
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      rdata     = {$urandom, $urandom};
      @(negedge clk);
      total++;
      last_wb = o_wb_data;
      if (o_wb_valid !== 1'b1 || o_wb_rd !== r || o_wb_data !== e_ld || o_req_ready !== 1'b0) begin
        bad++;
        $display("FAIL wb: got v=%b rd=%0d data=%h rdy=%b want v=1 rd=%0d data=%h rdy=0",
                 o_wb_valid, o_wb_rd, o_wb_data, o_req_ready, r, e_ld);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (o_req_ready !== 1'b1 || o_wb_valid !== 1'b0 || o_mem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_idle: got rdy=%b wb=%b mreq=%b want rdy=1 wb=0 mreq=0",
               o_req_ready, o_wb_valid, o_mem_req_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    for (int s = 0; s < 2; s++) begin
      sel64 = bit'(s);
      #0;
      total++;
      if (o_req_ready !== 1'b1 ||
          {o_mem_req_valid, o_mem_we, o_wb_valid, o_exc_valid, o_mem_addr, o_mem_wdata,
           o_mem_be, o_wb_rd, o_wb_data, o_exc_cause, o_exc_addr} !== '0) begin
        bad++;
        $display("FAIL %s x%0d: got rdy=%b mreq=%b we=%b wb=%b exc=%b addr=%h wd=%h be=%h rd=%0d wbd=%h cause=%0d eaddr=%h want rdy=1 rest 0",
                 tag, s ? 64 : 32, o_req_ready, o_mem_req_valid, o_mem_we, o_wb_valid,
                 o_exc_valid, o_mem_addr, o_mem_wdata, o_mem_be, o_wb_rd, o_wb_data,
                 o_exc_cause, o_exc_addr);
      end
    end
    sel64 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_state");
    @(posedge clk); #1;
  endtask

  task automatic expect_val(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++; $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_directed();
    run(0, 0, 3'b000, 32'h103, 64'h0, 5'd1, 64'h80FF1234, 0, 0);
    expect_val("lb_addr", 64'(last_maddr), 64'h100);
    expect_val("lb_be", 64'(last_be), 64'h8);
    expect_val("lb_data", last_wb, 64'hFFFFFF80);
    run(0, 0, 3'b101, 32'h102, 64'h0, 5'd2, 64'h80FF1234, 1, 2);
    expect_val("lhu_data", last_wb, 64'h000080FF);
    run(0, 0, 3'b001, 32'h102, 64'h0, 5'd3, 64'h80FF1234, 0, 1);
    expect_val("lh_data", last_wb, 64'hFFFF80FF);
    run(0, 1, 3'b000, 32'h101, 64'hAB, 5'd0, 64'h0, 3, 0);
    expect_val("sb_wdata", last_wdata, 64'h0000AB00);
    expect_val("sb_be", 64'(last_be), 64'h2);
    run(0, 0, 3'b010, 32'h102, 64'h0, 5'd4, 64'h0, 0, 0);
    expect_val("lw_mis_cause", 64'(last_cause), 64'd0);
    expect_val("lw_mis_addr", 64'(last_eaddr), 64'h102);
    expect_val("lw_mis_nomem", 64'(saw_mem), 64'd0);
    run(0, 1, 3'b110, 32'h100, 64'h1234, 5'd0, 64'h0, 0, 0);
    expect_val("sw_ill_cause", 64'(last_cause), 64'd2);
    run(1, 0, 3'b011, 32'h8, 64'h0, 5'd5, 64'h8000000000000001, 0, 0);
    expect_val("ld_be", 64'(last_be), 64'hFF);
    expect_val("ld_data", last_wb, 64'h8000000000000001);
    run(1, 0, 3'b110, 32'hC, 64'h0, 5'd6, 64'h8000000000000001, 0, 0);
    expect_val("lwu_data", last_wb, 64'h0000000080000000);
    run(0, 0, 3'b011, 32'h8, 64'h0, 5'd7, 64'h0, 0, 0);
    expect_val("ld_rv32_cause", 64'(last_cause), 64'd2);
    run(0, 0, 3'b000, 32'h40, 64'h0, 5'd0, 64'h000000FF, 0, 0);
    expect_val("lb_rd0", last_wb, 64'hFFFFFFFF);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 300; n++) begin
      a = $urandom & 32'h0000_FFF8;
      if ($urandom_range(0, 1) == 0) a = a | $urandom_range(0, 7);
      run(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 3'($urandom), a,
          {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
          $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    sel64 = 1'b0; req_we = 1'b0; f3 = 3'b010; addr = 32'h200; rd = 5'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    total++;
    if (o_mem_req_valid !== 1'b0 || o_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_wait: got mreq=%b rdy=%b want 0 0", o_mem_req_valid, o_req_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_valid = 1'b1; rdata = 64'h1234_5678;
    @(negedge clk);
    check_reset_values("mid_reset");
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    check_reset_values("late_rsp");
    @(posedge clk); #1;
    run(0, 0, 3'b100, 32'h201, 64'h0, 5'd10, 64'h0000C300, 0, 0);
    expect_val("after_reset_lbu", last_wb, 64'h000000C3);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
